// File: rtl/exec_mem_unit.sv
// Execution/memory slice: combinational 8-bit ALU, 8-bit barrel shifter/rotator,
// and a 256x8 data memory with asynchronous read and an asynchronous clear.
module exec_mem_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] alu_op,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic       alu_cin,
  output logic [7:0] alu_out,
  output logic       alu_co,
  output logic       alu_z,
  input  logic [7:0] sh_data,
  input  logic [2:0] sh_count,
  input  logic       sh_dir,
  input  logic       sh_ro_bar,
  output logic [7:0] sh_out,
  output logic       sh_c,
  output logic       sh_z,
  input  logic       mem_we,
  input  logic [7:0] mem_addr,
  input  logic [7:0] mem_wdata,
  output logic [7:0] mem_rdata
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_PASB = 3'b101,
    OP_PASA = 3'b110,
    OP_NOTA = 3'b111
  } aluOpE;

  logic [8:0] aluWide;
  logic [7:0] shRes;
  logic       shCarry;
  logic [3:0] rotBack;
  logic [7:0] mem_q [256];

  // For SUB the ninth bit of the 9-bit difference is set exactly when it went negative.
  always_comb begin
    aluWide = 9'd0;
    unique case (aluOpE'(alu_op))
      OP_ADD:  aluWide = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      OP_SUB:  aluWide = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      OP_AND:  aluWide = {1'b0, alu_a & alu_b};
      OP_OR:   aluWide = {1'b0, alu_a | alu_b};
      OP_XOR:  aluWide = {1'b0, alu_a ^ alu_b};
      OP_PASB: aluWide = {1'b0, alu_b};
      OP_PASA: aluWide = {1'b0, alu_a};
      OP_NOTA: aluWide = {1'b0, ~alu_a};
      default: aluWide = 9'd0;
    endcase
  end

  assign alu_out = aluWide[7:0];
  assign alu_co  = aluWide[8];
  assign alu_z   = (aluWide[7:0] == 8'h00);

  assign rotBack = 4'd8 - {1'b0, sh_count};

  // A guard bit beside the operand catches the last bit shifted out.
  always_comb begin
    shRes   = sh_data;
    shCarry = 1'b0;
    if (sh_count != 3'd0) begin
      unique case ({sh_ro_bar, sh_dir})
        2'b10: {shCarry, shRes} = {1'b0, sh_data} << sh_count;
        2'b11: {shRes, shCarry} = {sh_data, 1'b0} >> sh_count;
        2'b00: begin
          shRes   = (sh_data << sh_count) | (sh_data >> rotBack);
          shCarry = shRes[0];
        end
        2'b01: begin
          shRes   = (sh_data >> sh_count) | (sh_data << rotBack);
          shCarry = shRes[7];
        end
        default: begin
          shRes   = sh_data;
          shCarry = 1'b0;
        end
      endcase
    end
  end

  assign sh_out = shRes;
  assign sh_c   = shCarry;
  assign sh_z   = (shRes == 8'h00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_q[mem_addr];

endmodule

// File: tb/tb_exec_mem_unit.sv
// Bench for exec_mem_unit: an arithmetic reference model checked every cycle,
// plus literal expectations for the known corner cases.
module tb_exec_mem_unit;

  logic       clk;
  logic       reset;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic       alu_co, alu_z;
  logic [7:0] sh_data;
  logic [2:0] sh_count;
  logic       sh_dir, sh_ro_bar;
  logic [7:0] sh_out;
  logic       sh_c, sh_z;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  logic checkEn = 1'b0;
  logic [7:0] modelMem [256];

  exec_mem_unit dut (
    .clk(clk), .reset(reset),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z),
    .sh_data(sh_data), .sh_count(sh_count), .sh_dir(sh_dir), .sh_ro_bar(sh_ro_bar),
    .sh_out(sh_out), .sh_c(sh_c), .sh_z(sh_z),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference memory: cleared the instant reset falls, written only when out of reset.
  always @(negedge reset) begin
    for (int i = 0; i < 256; i++) modelMem[i] <= 8'h00;
  end

  always @(posedge clk) begin
    if (reset && mem_we) modelMem[mem_addr] <= mem_wdata;
  end

  function automatic void modelAlu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, output logic [7:0] o, output logic co);
    int r;
    r  = 0;
    co = 1'b0;
    case (op)
      3'd0: begin r = int'(a) + int'(b) + int'(cin); co = (r > 255); end
      3'd1: begin r = int'(a) - int'(b) - int'(cin); co = (int'(a) < int'(b) + int'(cin)); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(b);
      3'd6: r = int'(a);
      default: r = 255 - int'(a);
    endcase
    o = 8'(r);
  endfunction

  function automatic void modelShift(input logic [7:0] d, input int n, input logic dir,
                                     input logic logical, output logic [7:0] o, output logic c);
    o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int src;
      if (logical) begin
        src  = dir ? i + n : i - n;
        o[i] = (src >= 0 && src < 8) ? d[src] : 1'b0;
      end else begin
        src  = dir ? (i + n) % 8 : (i - n + 8) % 8;
        o[i] = d[src];
      end
    end
    if (n == 0)       c = 1'b0;
    else if (logical) c = dir ? d[n-1] : d[8-n];
    else              c = dir ? o[7] : o[0];
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge, all outputs are compared against the reference model.
  always @(negedge clk) begin
    if (checkEn) begin
      logic [7:0] eAlu, eSh;
      logic eCo, eC;
      modelAlu(alu_op, alu_a, alu_b, alu_cin, eAlu, eCo);
      modelShift(sh_data, int'(sh_count), sh_dir, sh_ro_bar, eSh, eC);
      checkOutput("model alu_out", alu_out, eAlu);
      checkOutput("model alu_co", {7'd0, alu_co}, {7'd0, eCo});
      checkOutput("model alu_z", {7'd0, alu_z}, {7'd0, eAlu == 8'h00});
      checkOutput("model sh_out", sh_out, eSh);
      checkOutput("model sh_c", {7'd0, sh_c}, {7'd0, eC});
      checkOutput("model sh_z", {7'd0, sh_z}, {7'd0, eSh == 8'h00});
      checkOutput("model mem_rdata", mem_rdata, modelMem[mem_addr]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic logical, input logic dir,
                               input logic [7:0] d, input logic [2:0] n);
    alu_op = op; alu_a = a; alu_b = b; alu_cin = cin;
    sh_ro_bar = logical; sh_dir = dir; sh_data = d; sh_count = n;
  endtask

  task automatic setMem(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    mem_we = we; mem_addr = addr; mem_wdata = wdata;
  endtask

  logic [7:0] aTab [4] = '{8'h00, 8'h7F, 8'h33, 8'hFF};
  logic [7:0] bTab [4] = '{8'h00, 8'h80, 8'h55, 8'hFF};
  logic [7:0] dTab [3] = '{8'hB4, 8'h01, 8'h80};

  initial begin
    applyStimulus(3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    setMem(1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 checkOutput("reset rdata", mem_rdata, 8'h00);
    step();
    step();
    reset = 1'b1;
    checkEn = 1'b1;

    step();
    applyStimulus(3'd0, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 8'h81, 3'd1);
    #1;
    checkOutput("add out", alu_out, 8'h00);
    checkOutput("add co", {7'd0, alu_co}, 8'h01);
    checkOutput("add z", {7'd0, alu_z}, 8'h01);
    checkOutput("shl out", sh_out, 8'h02);
    checkOutput("shl c", {7'd0, sh_c}, 8'h01);

    step();
    applyStimulus(3'd1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 8'h81, 3'd1);
    #1;
    checkOutput("sub out", alu_out, 8'hFE);
    checkOutput("sub co", {7'd0, alu_co}, 8'h01);
    checkOutput("sub z", {7'd0, alu_z}, 8'h00);
    checkOutput("shr out", sh_out, 8'h40);
    checkOutput("shr c", {7'd0, sh_c}, 8'h01);

    step();
    applyStimulus(3'd2, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h81, 3'd1);
    #1;
    checkOutput("and out", alu_out, 8'h00);
    checkOutput("and z", {7'd0, alu_z}, 8'h01);
    checkOutput("and co", {7'd0, alu_co}, 8'h00);
    checkOutput("rol out", sh_out, 8'h03);
    checkOutput("rol c", {7'd0, sh_c}, 8'h01);

    step();
    applyStimulus(3'd5, 8'h11, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1);
    #1;
    checkOutput("passb out", alu_out, 8'h3C);
    checkOutput("shr1 out", sh_out, 8'h00);
    checkOutput("shr1 c", {7'd0, sh_c}, 8'h01);
    checkOutput("shr1 z", {7'd0, sh_z}, 8'h01);

    for (int m = 0; m < 4; m++) begin
      step();
      applyStimulus(3'd7, 8'h0F, 8'h00, 1'b1, m[1], m[0], 8'hA5, 3'd0);
      #1;
      checkOutput("count0 out", sh_out, 8'hA5);
      checkOutput("count0 c", {7'd0, sh_c}, 8'h00);
    end

    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        applyStimulus(3'(op), aTab[k], bTab[(k + 1) % 4], k[0], 1'b1, 1'b0, 8'h00, 3'd0);
      end
    end
    for (int m = 0; m < 4; m++) begin
      for (int n = 0; n < 8; n++) begin
        for (int k = 0; k < 3; k++) begin
          step();
          applyStimulus(3'd0, 8'h00, 8'h00, 1'b0, m[1], m[0], dTab[k], 3'(n));
        end
      end
    end

    step();
    setMem(1'b1, 8'h10, 8'h5A);
    #1 checkOutput("rdw old word", mem_rdata, 8'h00);
    step();
    checkOutput("rdw new word", mem_rdata, 8'h5A);
    setMem(1'b1, 8'hFF, 8'hC3);
    step();
    setMem(1'b0, 8'h10, 8'h00);
    #1 checkOutput("read 10", mem_rdata, 8'h5A);
    step();
    setMem(1'b0, 8'hFF, 8'h00);
    #1 checkOutput("read FF", mem_rdata, 8'hC3);
    step();
    setMem(1'b0, 8'h11, 8'h99);
    #1 checkOutput("read 11", mem_rdata, 8'h00);
    step();
    setMem(1'b1, 8'h20, 8'h77);
    step();
    setMem(1'b1, 8'h10, 8'h66);

    #2 reset = 1'b0;
    #1 checkOutput("async clear", mem_rdata, 8'h00);
    applyStimulus(3'd0, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 8'h81, 3'd1);
    #1;
    checkOutput("alu in reset", alu_out, 8'h46);
    checkOutput("sh in reset", sh_out, 8'h02);
    step();
    setMem(1'b1, 8'h20, 8'hEE);
    step();
    checkOutput("we in reset", mem_rdata, 8'h00);
    setMem(1'b1, 8'h42, 8'hAB);
    #2 reset = 1'b1;
    #1 checkOutput("pre first write", mem_rdata, 8'h00);
    step();
    checkOutput("first write", mem_rdata, 8'hAB);
    setMem(1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 256; i++) begin
      step();
      mem_addr = 8'(i);
      #1 checkOutput("cleared word", mem_rdata, (i == 8'h42) ? 8'hAB : 8'h00);
    end

    step();
    step();
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
